// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory and decode-side bus of the fetch unit
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 6,
   parameter int INSTR_W = 16
);
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic [INSTR_W-1:0] ir_out;
   logic [ADDR_W-1:0]  pc_out;
   logic               ir_valid;
   logic               ir_ready;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               halt;
   logic               halted;

   modport master (
      output imem_addr, ir_out, pc_out, ir_valid, halted,
      input  imem_data, ir_ready, redirect, redirect_pc, halt
   );

   modport slave (
      input  imem_addr, ir_out, pc_out, ir_valid, halted,
      output imem_data, ir_ready, redirect, redirect_pc, halt
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, same-cycle imem read, IR with valid/ready, redirect and halt
module instr_fetch_unit #(
   parameter int                ADDR_W   = 6,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   instr_fetch_unit_if.master    bus
);
   typedef enum logic {
      RUN,
      HALTED
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
   logic               valid_q, valid_d;
   logic               load;

   assign bus.imem_addr = pc_q;
   assign bus.ir_out    = ir_q;
   assign bus.pc_out    = pc_out_q;
   assign bus.ir_valid  = valid_q;
   assign bus.halted    = (state_q == HALTED);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      load     = !valid_q || bus.ir_ready;
      if (bus.redirect) begin
         // Flush wins over acceptance: the held instruction is dropped.
         pc_d    = bus.redirect_pc;
         valid_d = 1'b0;
         state_d = RUN;
      end else if (state_q == HALTED || bus.halt) begin
         state_d = HALTED;
         if (valid_q && bus.ir_ready) begin
            valid_d = 1'b0;
         end
      end else if (load) begin
         ir_d     = bus.imem_data;
         pc_out_d = pc_q;
         valid_d  = 1'b1;
         pc_d     = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   instr_fetch_unit_if #(.ADDR_W(6), .INSTR_W(16)) bus ();

   instr_fetch_unit #(.ADDR_W(6), .INSTR_W(16), .RESET_PC(6'd0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // memory[i] = A000 + i, read combinationally
   assign bus.imem_data = 16'hA000 + {10'd0, bus.imem_addr};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.ir_ready = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_pc = 6'd0;
      bus.halt = 1'b0;
      step();
      step();
      n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.ir_valid); end
      n_cmp++; if (bus.ir_out !== 16'h0000) begin n_err++; $display("FAIL reset_ir got %h want 0000", bus.ir_out); end
      n_cmp++; if (bus.pc_out !== 6'd0) begin n_err++; $display("FAIL reset_pc_out got %0d want 0", bus.pc_out); end
      n_cmp++; if (bus.imem_addr !== 6'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", bus.imem_addr); end
      n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", bus.halted); end
   endtask

   task automatic test_stream();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         n_cmp++; if (bus.ir_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b want 1", i, bus.ir_valid); end
         n_cmp++; if (bus.ir_out !== 16'hA000 + 16'(i)) begin n_err++; $display("FAIL stream_ir[%0d] got %h want %h", i, bus.ir_out, 16'hA000 + 16'(i)); end
         n_cmp++; if (bus.pc_out !== 6'(i)) begin n_err++; $display("FAIL stream_pc_out[%0d] got %0d want %0d", i, bus.pc_out, i); end
         n_cmp++; if (bus.imem_addr !== 6'(i + 1)) begin n_err++; $display("FAIL stream_addr[%0d] got %0d want %0d", i, bus.imem_addr, i + 1); end
      end
   endtask

   task automatic test_stall();
      bus.ir_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (bus.ir_out !== 16'hA005) begin n_err++; $display("FAIL stall_ir[%0d] got %h want a005", i, bus.ir_out); end
         n_cmp++; if (bus.pc_out !== 6'd5) begin n_err++; $display("FAIL stall_pc_out[%0d] got %0d want 5", i, bus.pc_out); end
         n_cmp++; if (bus.imem_addr !== 6'd6) begin n_err++; $display("FAIL stall_addr[%0d] got %0d want 6", i, bus.imem_addr); end
         n_cmp++; if (bus.ir_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus.ir_valid); end
      end
      bus.ir_ready = 1'b1;
      step();
      n_cmp++; if (bus.ir_out !== 16'hA006) begin n_err++; $display("FAIL stall_resume_ir got %h want a006", bus.ir_out); end
      n_cmp++; if (bus.pc_out !== 6'd6) begin n_err++; $display("FAIL stall_resume_pc_out got %0d want 6", bus.pc_out); end
   endtask

   task automatic test_wrap();
      logic [5:0] exp_pc [4];
      exp_pc[0] = 6'd62; exp_pc[1] = 6'd63; exp_pc[2] = 6'd0; exp_pc[3] = 6'd1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 6'd62;
      step();
      n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++; $display("FAIL wrap_redirect_valid got %b want 0", bus.ir_valid); end
      n_cmp++; if (bus.imem_addr !== 6'd62) begin n_err++; $display("FAIL wrap_redirect_addr got %0d want 62", bus.imem_addr); end
      bus.redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (bus.pc_out !== exp_pc[i]) begin n_err++; $display("FAIL wrap_pc_out[%0d] got %0d want %0d", i, bus.pc_out, exp_pc[i]); end
         n_cmp++; if (bus.ir_out !== 16'hA000 + {10'd0, exp_pc[i]}) begin n_err++; $display("FAIL wrap_ir[%0d] got %h", i, bus.ir_out); end
         n_cmp++; if (bus.ir_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid[%0d] got %b want 1", i, bus.ir_valid); end
      end
   endtask

   task automatic test_redirect_flush();
      bus.ir_ready = 1'b0;
      bus.redirect = 1'b1;
      bus.redirect_pc = 6'd20;
      step();
      n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", bus.ir_valid); end
      n_cmp++; if (bus.imem_addr !== 6'd20) begin n_err++; $display("FAIL flush_addr got %0d want 20", bus.imem_addr); end
      bus.redirect = 1'b0;
      step();
      n_cmp++; if (bus.ir_valid !== 1'b1) begin n_err++; $display("FAIL flush_refill_valid got %b want 1", bus.ir_valid); end
      n_cmp++; if (bus.ir_out !== 16'hA014) begin n_err++; $display("FAIL flush_refill_ir got %h want a014", bus.ir_out); end
      n_cmp++; if (bus.pc_out !== 6'd20) begin n_err++; $display("FAIL flush_refill_pc_out got %0d want 20", bus.pc_out); end
      n_cmp++; if (bus.imem_addr !== 6'd21) begin n_err++; $display("FAIL flush_refill_addr got %0d want 21", bus.imem_addr); end
   endtask

   task automatic test_halt();
      bus.ir_ready = 1'b0;
      bus.redirect = 1'b1;
      bus.redirect_pc = 6'd8;
      step();
      bus.redirect = 1'b0;
      step();
      n_cmp++; if (bus.imem_addr !== 6'd9) begin n_err++; $display("FAIL halt_setup_addr got %0d want 9", bus.imem_addr); end
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL halt_halted got %b want 1", bus.halted); end
      n_cmp++; if (bus.ir_valid !== 1'b1) begin n_err++; $display("FAIL halt_held_valid got %b want 1", bus.ir_valid); end
      n_cmp++; if (bus.pc_out !== 6'd8) begin n_err++; $display("FAIL halt_held_pc_out got %0d want 8", bus.pc_out); end
      n_cmp++; if (bus.imem_addr !== 6'd9) begin n_err++; $display("FAIL halt_addr got %0d want 9", bus.imem_addr); end
      bus.ir_ready = 1'b1;
      step();
      n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++; $display("FAIL halt_accept_valid got %b want 0", bus.ir_valid); end
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++; if ({bus.halted, bus.ir_valid, bus.imem_addr, bus.pc_out} !== {1'b1, 1'b0, 6'd9, 6'd8})
            begin n_err++; $display("FAIL halt_idle[%0d] got halted=%b valid=%b addr=%0d pc_out=%0d", i, bus.halted, bus.ir_valid, bus.imem_addr, bus.pc_out); end
      end
      bus.redirect = 1'b1;
      bus.redirect_pc = 6'd3;
      step();
      bus.redirect = 1'b0;
      n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL halt_exit_halted got %b want 0", bus.halted); end
      step();
      n_cmp++; if (bus.ir_out !== 16'hA003) begin n_err++; $display("FAIL halt_exit_ir got %h want a003", bus.ir_out); end
      n_cmp++; if (bus.ir_valid !== 1'b1) begin n_err++; $display("FAIL halt_exit_valid got %b want 1", bus.ir_valid); end
   endtask

   task automatic test_priority_and_reset();
      bus.ir_ready = 1'b1;
      bus.redirect = 1'b1;
      bus.halt = 1'b1;
      bus.redirect_pc = 6'd40;
      step();
      bus.redirect = 1'b0;
      bus.halt = 1'b0;
      n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL prio_halted got %b want 0", bus.halted); end
      n_cmp++; if (bus.imem_addr !== 6'd40) begin n_err++; $display("FAIL prio_addr got %0d want 40", bus.imem_addr); end
      step();
      n_cmp++; if (bus.ir_out !== 16'hA028) begin n_err++; $display("FAIL prio_ir got %h want a028", bus.ir_out); end
      n_cmp++; if (bus.pc_out !== 6'd40) begin n_err++; $display("FAIL prio_pc_out got %0d want 40", bus.pc_out); end
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL prio_halt_again got %b want 1", bus.halted); end
      rst = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 6'd30;
      step();
      rst = 1'b0;
      bus.redirect = 1'b0;
      n_cmp++; if (bus.imem_addr !== 6'd0) begin n_err++; $display("FAIL rst_mid_addr got %0d want 0", bus.imem_addr); end
      n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", bus.ir_valid); end
      n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL rst_mid_halted got %b want 0", bus.halted); end
      n_cmp++; if (bus.ir_out !== 16'h0000) begin n_err++; $display("FAIL rst_mid_ir got %h want 0000", bus.ir_out); end
      step();
      n_cmp++; if (bus.ir_out !== 16'hA000) begin n_err++; $display("FAIL rst_mid_refetch_ir got %h want a000", bus.ir_out); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_wrap();
      test_redirect_flush();
      test_halt();
      test_priority_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
